// File: rtl/f2i_arb_pkg.sv
// f2i_arb_pkg: shared state encoding and constants for the float-to-int arbiter.
package f2i_arb_pkg;
    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] SENTINEL = 32'h8000_0000;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESULT, DELIVER} state_t;
endpackage

// File: rtl/f2i_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wraparound.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);
    int j;
    always_comb begin
        grant = '0;
        idx = '0;
        valid = 1'b0;
        j = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!valid && req[j]) begin
                grant[j] = 1'b1;
                idx = IW'(j);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/f2i_arbiter.sv
// f2i_arbiter: shares one float-to-int converter among NREQ requesters, one operation in flight.
// Define F2I_ARB_TIMEOUT_EN to add a converter watchdog that delivers SENTINEL and discards the late result.
module f2i_arbiter
    import f2i_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ*WORD_W-1:0] req_a,
    input  logic [NREQ-1:0]        req_a_stb,
    output logic [NREQ-1:0]        req_a_ack,
    output logic [WORD_W-1:0]      req_z,
    output logic [NREQ-1:0]        req_z_stb,
    input  logic [NREQ-1:0]        req_z_ack,
    output logic [WORD_W-1:0]      cvt_input_a,
    output logic                   cvt_input_a_stb,
    input  logic                   cvt_input_a_ack,
    input  logic [WORD_W-1:0]      cvt_output_z,
    input  logic                   cvt_output_z_stb,
    output logic                   cvt_output_z_ack,
    output logic                   busy
);
    localparam int IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("f2i_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
    end

    state_t          state;
    logic [IW-1:0]   id, ptr, win_idx;
    logic [NREQ-1:0] win_grant;
    logic            win_valid, hold_off;

    rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
        .req   (req_a_stb),
        .ptr   (ptr),
        .grant (win_grant),
        .idx   (win_idx),
        .valid (win_valid)
    );

`ifdef F2I_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic          stale;
    assign hold_off = stale;
`else
    assign hold_off = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            id <= '0;
            ptr <= '0;
            req_a_ack <= '0;
            req_z <= '0;
            req_z_stb <= '0;
            cvt_input_a <= '0;
            cvt_input_a_stb <= 1'b0;
            cvt_output_z_ack <= 1'b0;
            busy <= 1'b0;
`ifdef F2I_ARB_TIMEOUT_EN
            cnt <= '0;
            stale <= 1'b0;
`endif
        end else begin
            req_a_ack <= '0;
            cvt_output_z_ack <= 1'b0;
            case (state)
                IDLE: if (win_valid && !hold_off) begin
                    id <= win_idx;
                    cvt_input_a <= req_a[WORD_W*win_idx +: WORD_W];
                    cvt_input_a_stb <= 1'b1;
                    req_a_ack <= win_grant;
                    busy <= 1'b1;
                    state <= ISSUE;
                end
                ISSUE: if (cvt_input_a_ack) begin
                    cvt_input_a_stb <= 1'b0;
                    state <= WAIT_RESULT;
                end
                WAIT_RESULT: if (cvt_output_z_stb) begin
                    req_z <= cvt_output_z;
                    cvt_output_z_ack <= 1'b1;
                    req_z_stb <= NREQ'(1) << id;
                    state <= DELIVER;
                end
                DELIVER: if (req_z_ack[id]) begin
                    req_z_stb <= '0;
                    busy <= 1'b0;
                    ptr <= (id == IW'(NREQ - 1)) ? '0 : id + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
`ifdef F2I_ARB_TIMEOUT_EN
            if (state == ISSUE || state == WAIT_RESULT) begin
                cnt <= cnt + 1'b1;
                if (cnt == CW'(TIMEOUT - 1) && !(state == WAIT_RESULT && cvt_output_z_stb)) begin
                    cvt_input_a_stb <= 1'b0;
                    req_z <= SENTINEL;
                    req_z_stb <= NREQ'(1) << id;
                    // only an operand the converter actually took can produce a late result
                    stale <= state == WAIT_RESULT || cvt_input_a_ack;
                    state <= DELIVER;
                end
            end else begin
                cnt <= '0;
            end
            if (stale && cvt_output_z_stb && !cvt_output_z_ack) begin
                cvt_output_z_ack <= 1'b1;
                stale <= 1'b0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_f2i_arbiter.sv
// tb_f2i_arbiter: scoreboard bench with a truncating 3-cycle converter model and a round-robin reference.
module tb_f2i_arbiter;
    import f2i_arb_pkg::*;
    localparam int NREQ = 4;
`ifdef F2I_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NREQ*32-1:0] req_a = '0;
    logic [NREQ-1:0] req_a_stb = '0;
    logic [NREQ-1:0] req_a_ack;
    logic [31:0] req_z;
    logic [NREQ-1:0] req_z_stb;
    logic [NREQ-1:0] req_z_ack = '0;
    logic [31:0] cvt_input_a;
    logic cvt_input_a_stb;
    logic cvt_input_a_ack = 1'b0;
    logic [31:0] cvt_output_z = '0;
    logic cvt_output_z_stb = 1'b0;
    logic cvt_output_z_ack;
    logic busy;

    int tests = 0;
    int fails = 0;
    logic [NREQ-1:0] stb_seen = '0;
    int mptr = 0;
    int ord_q[$];
    logic [31:0] exp_q[NREQ][$];
    bit hold = 0, ack_phase = 0;
    int hold_cnt = 0, w_cur = 0, ack_idx = 0, force_delay = -1;
    logic [31:0] hold_val = '0;
    bit silent = 0;
    int cst = 0, ccnt = 0, got_ack = 0;
    logic [31:0] cop = '0;

    f2i_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .req_a_stb(req_a_stb), .req_a_ack(req_a_ack),
        .req_z(req_z), .req_z_stb(req_z_stb), .req_z_ack(req_z_ack),
        .cvt_input_a(cvt_input_a), .cvt_input_a_stb(cvt_input_a_stb), .cvt_input_a_ack(cvt_input_a_ack),
        .cvt_output_z(cvt_output_z), .cvt_output_z_stb(cvt_output_z_stb), .cvt_output_z_ack(cvt_output_z_ack),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) stb_seen <= req_a_stb;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: actual %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] f2i(input logic [31:0] a);
        int e;
        logic [63:0] m;
        logic [31:0] r;
        e = int'(a[30:23]) - 127;
        if (e < 0) return 32'h0;
        if (e > 30) return 32'h8000_0000;
        m = {40'd0, 1'b1, a[22:0]};
        m = (e >= 23) ? m << (e - 23) : m >> (23 - e);
        r = m[31:0];
        return a[31] ? -r : r;
    endfunction

    function automatic logic [31:0] rand_float();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 150)), 23'($urandom)};
    endfunction

    // converter: ack the operand, then present the truncated result until acked
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            cvt_input_a_ack = 1'b0;
            cvt_output_z_stb = 1'b0;
            cvt_output_z = '0;
            cst = 0;
            continue;
        end
        case (cst)
            0: if (cvt_input_a_stb) begin cvt_input_a_ack = 1'b1; cop = cvt_input_a; cst = 1; end
            1: begin cvt_input_a_ack = 1'b0; ccnt = 1; cst = 2; end
            2: if (ccnt > 0) ccnt--;
               else if (!silent) begin cvt_output_z = f2i(cop); cvt_output_z_stb = 1'b1; cst = 3; end
            default: if (cvt_output_z_ack) begin cvt_output_z_stb = 1'b0; cst = 0; got_ack++; end
        endcase
    end

    // monitor: checks grants against the rotation rule and results against the scoreboard
    initial begin
        int w, pw;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mptr = 0; hold = 0; ack_phase = 0; req_z_ack = '0;
                ord_q.delete();
                for (int i = 0; i < NREQ; i++) exp_q[i].delete();
                continue;
            end
            if (|req_a_ack) begin
                w = -1;
                for (int k = 0; k < NREQ; k++)
                    if (w < 0 && stb_seen[(mptr + k) % NREQ]) w = (mptr + k) % NREQ;
                check(w >= 0 && req_a_ack == (NREQ'(1) << w), "grant", 32'(req_a_ack),
                      w < 0 ? 32'h0 : 32'(NREQ'(1) << w));
                ord_q.push_back(w < 0 ? 0 : w);
            end
            if (ack_phase) begin
                req_z_ack = '0; ack_phase = 0; hold = 0;
                mptr = (w_cur + 1) % NREQ;
                check(req_z_stb == '0, "z_stb_release", 32'(req_z_stb), 32'h0);
            end else if (hold) begin
                check(req_z == hold_val && req_z_stb == (NREQ'(1) << ack_idx), "z_stable", req_z, hold_val);
                if (hold_cnt == 0) begin req_z_ack[ack_idx] = 1'b1; ack_phase = 1; end
                else hold_cnt--;
            end else if (|req_z_stb) begin
                pw = 0;
                for (int k = 0; k < NREQ; k++) if (req_z_stb[k]) pw = k;
                if (ord_q.size() == 0) begin
                    check(0, "z_unexpected", 32'(req_z_stb), 32'h0);
                    w_cur = pw;
                end else begin
                    w_cur = ord_q.pop_front();
                    check(req_z_stb == (NREQ'(1) << w_cur), "z_owner", 32'(req_z_stb), 32'(NREQ'(1) << w_cur));
                    if (exp_q[w_cur].size() == 0) check(0, "z_no_expect", req_z, 32'h0);
                    else begin
                        e = exp_q[w_cur].pop_front();
                        check(req_z == e, "z_value", req_z, e);
                    end
                end
                ack_idx = pw;
                hold = 1;
                hold_val = req_z;
                hold_cnt = force_delay >= 0 ? force_delay : int'($urandom_range(0, 3));
            end
        end
    end

    task automatic send(input int i, input logic [31:0] a, input logic [31:0] e, input bit chk_lat);
        int n;
        @(negedge clk);
        req_a[32*i +: 32] = a;
        req_a_stb[i] = 1'b1;
        exp_q[i].push_back(e);
        n = 0;
        do begin @(negedge clk); n++; end while (!req_a_ack[i] && n < 3000);
        if (!req_a_ack[i]) check(0, "ack_timeout", 32'(n), 32'h0);
        else if (chk_lat) check(n == 1, "ack_latency", 32'(n), 32'h1);
        req_a_stb[i] = 1'b0;
    endtask

    task automatic drain();
        int n, p;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            p = int'(hold);
            for (int i = 0; i < NREQ; i++) p += exp_q[i].size();
        end while (p != 0 && n < 3000);
        if (p != 0) check(0, "drain_timeout", 32'(p), 32'h0);
        @(negedge clk);
        check(busy == 1'b0, "idle_busy", 32'(busy), 32'h0);
    endtask

    task automatic worker(input int i);
        logic [31:0] a;
        repeat (6) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            a = rand_float();
            send(i, a, f2i(a), 0);
        end
    endtask

    task automatic check_zero_outs(input string tag);
        check(busy == 1'b0, {tag, "_busy"}, 32'(busy), 32'h0);
        check(req_a_ack == '0, {tag, "_a_ack"}, 32'(req_a_ack), 32'h0);
        check(req_z_stb == '0, {tag, "_z_stb"}, 32'(req_z_stb), 32'h0);
        check(req_z == '0, {tag, "_z"}, req_z, 32'h0);
        check(cvt_input_a == '0, {tag, "_cvt_a"}, cvt_input_a, 32'h0);
        check(cvt_input_a_stb == 1'b0, {tag, "_cvt_a_stb"}, 32'(cvt_input_a_stb), 32'h0);
        check(cvt_output_z_ack == 1'b0, {tag, "_cvt_z_ack"}, 32'(cvt_output_z_ack), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, n;
        repeat (3) @(negedge clk);
        check_zero_outs("reset");
        rst_n = 1'b1;

        send(0, 32'h3F80_0000, 32'h0000_0001, 1);
        drain();

        // abandon an operation in WAIT_RESULT with an asynchronous reset
        @(negedge clk);
        req_a[32 +: 32] = 32'h4120_0000;
        req_a_stb[1] = 1'b1;
        @(negedge clk);
        req_a_stb[1] = 1'b0;
        repeat (2) @(negedge clk);
        check(busy == 1'b1, "busy_in_wait", 32'(busy), 32'h1);
        #2 rst_n = 1'b0;
        #1 check_zero_outs("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check(req_z_stb == '0, "no_z_after_rst", 32'(req_z_stb), 32'h0);
        end

        fork
            send(0, 32'h3F80_0000, 32'd1, 0);
            send(1, 32'h4000_0000, 32'd2, 0);
            send(2, 32'h4040_0000, 32'd3, 0);
            send(3, 32'h4080_0000, 32'd4, 0);
        join
        drain();
        fork
            send(0, 32'h40A0_0000, 32'd5, 0);
            send(1, 32'h40C0_0000, 32'd6, 0);
            send(2, 32'h40E0_0000, 32'd7, 0);
            send(3, 32'h4100_0000, 32'd8, 0);
        join
        drain();

        force_delay = 5;
        send(2, 32'hC020_0000, 32'hFFFF_FFFE, 1);
        drain();
        force_delay = -1;

        fork
            worker(0);
            worker(1);
            worker(2);
            worker(3);
        join
        drain();

`ifdef F2I_ARB_TIMEOUT_EN
        silent = 1;
        send(3, 32'h4000_0000, SENTINEL, 0);
        drain();
        g0 = got_ack;
        silent = 0;
        n = 0;
        while (got_ack == g0 && n < 50) begin @(negedge clk); n++; end
        check(got_ack > g0, "stale_discard", 32'(got_ack - g0), 32'h1);
        repeat (5) @(negedge clk);
        send(0, 32'h4040_0000, 32'd3, 1);
        drain();
`else
        g0 = 0;
        n = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
